pdm_demod: RTL

//  Receive end of the first-order PDM link: decimates a 1-bit PDM stream back to a

---
 rtl/pdm_pkg.sv | 14 +
 rtl/pdm_window_counter.sv | 37 +++
 rtl/pdm_demod.sv | 114 +++++++++++
 3 files changed

// File: rtl/pdm_pkg.sv
// Shared PDM link definitions: FSM state encoding and the default widths
// common to the modulator and demodulator sides.
package pdm_pkg;

    localparam int PDM_DECIM_LOG2 = 5;
    localparam int PDM_OUT_W      = 5;

    typedef logic [1:0] pdm_state_t;

    localparam pdm_state_t ST_IDLE    = 2'd0;
    localparam pdm_state_t ST_DISCARD = 2'd1;
    localparam pdm_state_t ST_RUN     = 2'd2;

endpackage

// File: rtl/pdm_window_counter.sv
// Sample index and ones accumulator for one decimation window; count includes
// the bit being taken so a window result is available on its last sample edge.
module pdm_window_counter
    import pdm_pkg::*;
#(
    parameter int DECIM_LOG2 = PDM_DECIM_LOG2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  sample,
    input  logic                  bit_in,
    output logic                  window_done,
    output logic [DECIM_LOG2:0]   count
);

    logic [DECIM_LOG2-1:0] idx;
    logic [DECIM_LOG2:0]   ones;

    assign count       = ones + {{DECIM_LOG2{1'b0}}, bit_in};
    assign window_done = sample && (idx == {DECIM_LOG2{1'b1}});

    // NOTE: non-blocking assignments so every flop updates from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx  <= '0;
            ones <= '0;
        end else if (clear) begin
            idx  <= '0;
            ones <= '0;
        end else if (sample) begin
            idx  <= idx + 1'b1;
            ones <= window_done ? '0 : count;
        end
    end

endmodule

// File: rtl/pdm_demod.sv
// PDM-to-PCM decimator with valid/ready output. Define PDM_DEMOD_SYNC_EN to
// insert a 2-flop synchroniser on pdm_in (adds 2 clk of input delay).
module pdm_demod
    import pdm_pkg::*;
#(
    parameter int DECIM_LOG2   = PDM_DECIM_LOG2,
    parameter int OUT_W        = PDM_OUT_W,
    parameter int SKIP_WINDOWS = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             sample_en,
    input  logic             pdm_in,
    output logic [OUT_W-1:0] pcm_data,
    output logic             pcm_valid,
    input  logic             pcm_ready,
    output logic             overrun
);

    localparam int         CW           = DECIM_LOG2 + 1;
    localparam logic [1:0] LAST_DISCARD = 2'(SKIP_WINDOWS - 1);

    pdm_state_t        state, next_state;
    logic [1:0]        discard_cnt;
    logic              pdm_bit;
    logic              window_done;
    logic [CW-1:0]     count;
    logic [OUT_W-1:0]  result;
    logic              new_result;

`ifdef PDM_DEMOD_SYNC_EN
    logic [1:0] pdm_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pdm_sync <= 2'b00;
        else          pdm_sync <= {pdm_sync[0], pdm_in};
    end

    assign pdm_bit = pdm_sync[1];
`else
    assign pdm_bit = pdm_in;
`endif

    pdm_window_counter #(
        .DECIM_LOG2 (DECIM_LOG2)
    ) u_window (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (state == ST_IDLE),
        .sample      (sample_en && (state != ST_IDLE)),
        .bit_in      (pdm_bit),
        .window_done (window_done),
        .count       (count)
    );

    // Saturate only at the output; the count itself can reach N.
    generate
        if (OUT_W < CW) begin : g_sat
            localparam logic [CW-1:0] SAT_MAX = CW'((1 << OUT_W) - 1);
            assign result = (count > SAT_MAX) ? {OUT_W{1'b1}} : count[OUT_W-1:0];
        end else if (OUT_W == CW) begin : g_exact
            assign result = count;
        end else begin : g_wide
            assign result = {{(OUT_W - CW){1'b0}}, count};
        end
    endgenerate

    assign new_result = window_done && (state == ST_RUN);

    // NOTE: next_state gets a default first so no branch can infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (en) next_state = (SKIP_WINDOWS > 0) ? ST_DISCARD : ST_RUN;
            ST_DISCARD: if (window_done && (discard_cnt == LAST_DISCARD)) next_state = ST_RUN;
            ST_RUN:     next_state = ST_RUN;
            default:    next_state = ST_IDLE;
        endcase
        if (!en) next_state = ST_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            discard_cnt <= 2'd0;
        end else begin
            state <= next_state;
            if (state == ST_IDLE)
                discard_cnt <= 2'd0;
            else if ((state == ST_DISCARD) && window_done)
                discard_cnt <= discard_cnt + 2'd1;
        end
    end

    // A fresh result always wins; overrun records that an unaccepted one was lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcm_data  <= '0;
            pcm_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (state == ST_IDLE) begin
            pcm_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (new_result) begin
            pcm_data  <= result;
            pcm_valid <= 1'b1;
            if (pcm_valid && !pcm_ready) overrun <= 1'b1;
        end else if (pcm_valid && pcm_ready) begin
            pcm_valid <= 1'b0;
        end
    end

endmodule
